stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Run/pause/lap/clear controller for the stopwatch datapath. It debounces two raw push-buttons and runs a four-state mode FSM. It produces the gated 1 Hz count tick that drives the seconds/minutes/hours counters, a clear pulse for those counters, and a hold level that freezes the 7-segment multiplexer on a lap time. It sits between the board buttons and the counter/display chain, and replaces the free-running 1 Hz divider plus raw Start level.

## Interface
- CLK_HZ, 100_000_000, input clock frequency
- TICK_HZ, 1, count_tick rate while counting; CLK_HZ/TICK_HZ must be an integer ≥ 2
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level (10 ms at 100 MHz); must be ≥ 1

- clock_100Mhz  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-low reset; deassertion is synchronous to clock_100Mhz
- btn_start  in  1  raw start/stop button, active-high, asynchronous to clock
- btn_lap  in  1  raw lap/clear button, active-high, asynchronous to clock
- count_tick  out  1  one-cycle pulse at TICK_HZ while counting
- clear  out  1  one-cycle pulse commanding counters to zero
- hold  out  1  level; display shows the frozen lap value while high
- running  out  1  high in RUNNING or LAP
- mode  out  2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 LAP

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: counter increments while sync ≠ debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the sync value and the counter clears.
- A press is a registered 1-cycle pulse on a 0→1 change of the debounced level. Release generates no event.
- FSM transitions (all other press/state pairs are ignored):
  - IDLE + start → RUNNING
  - RUNNING + start → PAUSED
  - PAUSED + start → RUNNING
  - LAP + start → PAUSED, hold drops
  - RUNNING + lap → LAP, hold rises
  - LAP + lap → RUNNING, hold drops
  - PAUSED + lap → IDLE, with a 1-cycle clear pulse in the transition cycle
- Simultaneous start and lap presses in the same cycle: the start press is taken and the lap press is discarded.
- Prescaler, width clog2(CLK_HZ/TICK_HZ):
  - Counts 0..CLK_HZ/TICK_HZ-1 while running=1.
  - Holds its value in PAUSED, so a partial period is preserved across a pause.
  - Forced to 0 in IDLE.
  - count_tick=1 in the cycle the prescaler equals its terminal value; the prescaler wraps to 0 in the same cycle.
- count_tick keeps running in LAP: the counters advance while the display is frozen.

## Timing
- Reset (reset=0) values:
  - Outputs: mode=00, count_tick=0, clear=0, hold=0, running=0.
  - Internal: synchronizers, debounced levels and all counters are 0.
- Reset asserted mid-operation forces the reset values immediately (asynchronous). Any in-progress debounce is discarded.
- Latency from a raw button 0→1 edge (meeting setup) to the mode/hold/running/clear change is exactly DEBOUNCE_CYCLES+4 clocks:
  - 2 clocks synchronizer
  - DEBOUNCE_CYCLES clocks debounce
  - 1 clock press register
  - 1 clock FSM
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- The first count_tick after IDLE→RUNNING occurs CLK_HZ/TICK_HZ cycles after the first RUNNING cycle.
- The transition cycle into PAUSED or IDLE produces no count_tick, even if the prescaler is at its terminal value.
- clear is never high in the same cycle as count_tick.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- STOPWATCH_LAP_EN defined:
  - Lap function present as specified.
- STOPWATCH_LAP_EN undefined:
  - LAP state is unreachable; hold is tied to 0.
  - A lap press in RUNNING is ignored.
  - A lap press in PAUSED still clears and returns to IDLE.
  - mode never reads 11.

## Test plan
Bench uses CLK_HZ=20, TICK_HZ=1, DEBOUNCE_CYCLES=4.
- Reset, then a clean 10-cycle btn_start pulse:
  - mode goes 00→01 exactly 8 clocks after the raw edge.
  - First count_tick follows 20 clocks later, then one every 20 clocks.
- Glitch rejection: btn_start high for 3 cycles, low for 10 → mode stays 00; no count_tick.
- Pause/resume: start, then start again 7 cycles after the 2nd tick:
  - No ticks occur during PAUSED.
  - After resume, the next tick arrives 13 clocks after the first RUNNING cycle (preserved prescaler).
- Lap, with STOPWATCH_LAP_EN defined:
  - In RUNNING, a lap press makes hold=1 and mode=11, and count_tick continues.
  - A second lap press makes hold=0 and mode=01.
  - Build without the macro: a lap press in RUNNING leaves mode=01 and hold=0.
- Clear and priority:
  - In PAUSED, a lap press gives exactly one clear pulse and mode=00.
  - Start and lap raw edges in the same cycle from RUNNING give mode=10 with no clear.
- Async reset mid-run: drive reset low for 1 ns between clock edges while in LAP → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and control outputs of the stopwatch controller.
// The master side drives the buttons (board/bench). The slave side is the controller.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       count_tick;
  logic       clear;
  logic       hold;
  logic       running;
  logic [1:0] mode;

  modport master (
    output btn_start, btn_lap,
    input  count_tick, clear, hold, running, mode
  );

  modport slave (
    input  btn_start, btn_lap,
    output count_tick, clear, hold, running, mode
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounces start/lap buttons and runs the IDLE/RUNNING/PAUSED/LAP
// mode FSM. It drives the gated count tick, the counter clear pulse and the display hold.
// Optional lap function: define STOPWATCH_LAP_EN. Without it, LAP is unreachable and hold stays 0.

// Per-button synchronizer, debouncer and rising-edge press pulse.
module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2, level, level_q;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Take a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Register a one-cycle pulse on a 0->1 change of the debounced level.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);
  localparam int NUM_BTN = 2;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PW      = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    LAP     = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] btn_raw, press;
  state_t             state, state_nxt;
  logic [PW-1:0]      pre, pre_nxt;
  logic               tick_nxt, clear_nxt, run_cur, run_nxt;
  logic               tick_q, clear_q, running_q;

  // Bit 0 is start, bit 1 is lap.
  assign btn_raw = {sw.btn_lap, sw.btn_start};

  stopwatch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn          (btn_raw),
    .press        (press)
  );

  // Mode transitions. A start press wins over a lap press in the same cycle.
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    unique case (state)
      IDLE:    if (press[0]) state_nxt = RUNNING;
      RUNNING: begin
        if (press[0]) state_nxt = PAUSED;
`ifdef STOPWATCH_LAP_EN
        else if (press[1]) state_nxt = LAP;
`endif
      end
      PAUSED:  begin
        if (press[0]) state_nxt = RUNNING;
        else if (press[1]) begin
          state_nxt = IDLE;
          clear_nxt = 1'b1;
        end
      end
      LAP:     begin
        if (press[0]) state_nxt = PAUSED;
        else if (press[1]) state_nxt = RUNNING;
      end
    endcase
  end

  assign run_cur = (state == RUNNING) || (state == LAP);
  assign run_nxt = (state_nxt == RUNNING) || (state_nxt == LAP);

  // Prescaler advances only while staying in a counting state, so the edge into
  // PAUSED never ticks and a partial period survives a pause.
  always_comb begin
    pre_nxt  = pre;
    tick_nxt = 1'b0;
    if (state_nxt == IDLE) begin
      pre_nxt = '0;
    end else if (run_cur && run_nxt) begin
      if (pre == PRE_LAST) begin
        pre_nxt  = '0;
        tick_nxt = 1'b1;
      end else begin
        pre_nxt = pre + 1'b1;
      end
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pre       <= '0;
      tick_q    <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre       <= pre_nxt;
      tick_q    <= tick_nxt;
      clear_q   <= clear_nxt;
      running_q <= run_nxt;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic hold_q;

  // Hold the display while in LAP.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) hold_q <= 1'b0;
    else        hold_q <= (state_nxt == LAP);
  end

  assign sw.hold = hold_q;
`else
  assign sw.hold = 1'b0;
`endif

  assign sw.mode       = state;
  assign sw.count_tick = tick_q;
  assign sw.clear      = clear_q;
  assign sw.running    = running_q;
endmodule
